// File: rtl/pipe_issuer_if.sv
// Issuer-side bus: program load port, start request and the instruction/status
// outputs that feed the register/ALU/memory pipeline.
interface pipe_issuer_if #(
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic          ld_en;
   logic [AW-1:0] ld_addr;
   logic [23:0]   ld_data;
   logic          start;
   logic [AW:0]   prog_len;

   logic          busy;
   logic          done;
   logic          issue_valid;
   logic [3:0]    rs1;
   logic [3:0]    rs2;
   logic [3:0]    rd;
   logic [3:0]    func;
   logic [7:0]    addr;
   logic [AW-1:0] pc;
   logic [7:0]    stall_cnt;

   modport master (
      output ld_en, ld_addr, ld_data, start, prog_len,
      input  busy, done, issue_valid, rs1, rs2, rd, func, addr, pc, stall_cnt
   );

   modport slave (
      input  ld_en, ld_addr, ld_data, start, prog_len,
      output busy, done, issue_valid, rs1, rs2, rd, func, addr, pc, stall_cnt
   );
endinterface

// File: rtl/pipe_issuer.sv
// Instruction issuer: runs a loaded program one instruction per clock into a
// non-forwarding pipeline, inserting bubbles on read-after-write hazards.
module pipe_issuer #(
   parameter int DEPTH     = 16,
   parameter int HAZ_GAP   = 2,
   parameter int DRAIN_CYC = 3
) (
   input logic          clk1,
   input logic          rst,
   pipe_issuer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = $clog2(DRAIN_CYC + 2);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [3:0] func;
      logic [3:0] rs1;
      logic [3:0] rs2;
      logic [3:0] rd;
      logic [7:0] addr;
   } instr_t;

   typedef struct packed {
      logic       v;
      logic [3:0] rd;
   } slot_t;

   state_t        state, state_nxt;
   instr_t        mem [DEPTH];
   instr_t        cur;
   instr_t        out_q;
   slot_t         trk [HAZ_GAP];
   logic [AW-1:0] pc_q;
   logic [AW:0]   len_q;
   logic [7:0]    stall_q;
   logic [DW-1:0] drain_q;
   logic          valid_q;
   logic          hazard;
   logic          last_issue;

   assign cur        = mem[pc_q];
   assign last_issue = ({1'b0, pc_q} == len_q - (AW + 1)'(1));

   // NOTE: the program buffer has no reset; clearing a RAM costs a write port per
   // entry and software always loads before starting.
   always_ff @(posedge clk1) begin
      if (bus.ld_en && (state == IDLE || state == DONE))
         mem[bus.ld_addr] <= bus.ld_data;
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = (bus.prog_len == '0) ? DONE : RUN;
         RUN:     if (!hazard && last_issue) state_nxt = DRAIN;
         DRAIN:   if (drain_q == DW'(DRAIN_CYC)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == RUN) || (state == DRAIN);
      bus.done = (state == DONE);
   end

   // Only instructions already issued sit in the tracker, so self-dependency never stalls.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < HAZ_GAP; i++)
         if (trk[i].v && (trk[i].rd == cur.rs1 || trk[i].rd == cur.rs2))
            hazard = 1'b1;
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         out_q   <= '0;
         pc_q    <= '0;
         len_q   <= '0;
         stall_q <= '0;
         drain_q <= '0;
         for (int i = 0; i < HAZ_GAP; i++) trk[i] <= '0;
      end else begin
         valid_q <= 1'b0;
         if (state == RUN || state == DRAIN)
            for (int i = HAZ_GAP - 1; i > 0; i--) trk[i] <= trk[i-1];
         case (state)
            IDLE: begin
               if (bus.start) begin
                  pc_q    <= '0;
                  stall_q <= '0;
                  len_q   <= bus.prog_len;
                  for (int i = 0; i < HAZ_GAP; i++) trk[i] <= '0;
               end
            end
            RUN: begin
               drain_q <= '0;
               trk[0]  <= {!hazard, cur.rd};
               if (hazard) begin
                  if (stall_q != 8'hFF) stall_q <= stall_q + 8'd1;
               end else begin
                  valid_q <= 1'b1;
                  out_q   <= cur;
                  pc_q    <= pc_q + AW'(1);
               end
            end
            DRAIN: begin
               trk[0]  <= '0;
               drain_q <= drain_q + DW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.issue_valid = valid_q;
   assign bus.func        = out_q.func;
   assign bus.rs1         = out_q.rs1;
   assign bus.rs2         = out_q.rs2;
   assign bus.rd          = out_q.rd;
   assign bus.addr        = out_q.addr;
   assign bus.pc          = pc_q;
   assign bus.stall_cnt   = stall_q;
endmodule

// File: tb/tb_pipe_issuer.sv
// Directed bench for pipe_issuer: expected issues are queued per run and matched
// against the DUT as it issues, alongside done timing, busy, stall and pc checks.
module tb_pipe_issuer;
   localparam int DEPTH = 16;

   logic clk1 = 1'b0;
   logic rst  = 1'b1;
   always #5 clk1 = ~clk1;

   pipe_issuer_if #(.DEPTH(DEPTH)) bus ();

   pipe_issuer #(.DEPTH(DEPTH), .HAZ_GAP(2), .DRAIN_CYC(3)) dut (
      .clk1 (clk1),
      .rst  (rst),
      .bus  (bus)
   );

   typedef struct {
      int          edge_n;
      logic [23:0] ins;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [23:0] mk(input int f, input int r1, input int r2, input int d, input int a);
      return {4'(f), 4'(r1), 4'(r2), 4'(d), 8'(a)};
   endfunction

   function automatic logic [23:0] outs();
      return {bus.func, bus.rs1, bus.rs2, bus.rd, bus.addr};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int idx, input logic [23:0] d);
      bus.ld_en   = 1'b1;
      bus.ld_addr = 4'(idx);
      bus.ld_data = d;
      @(posedge clk1); #1;
      bus.ld_en   = 1'b0;
   endtask

   task automatic expect_issue(input int e, input logic [23:0] ins);
      exp_t x;
      x.edge_n = e;
      x.ins    = ins;
      sb.push_back(x);
   endtask

   // Starts a run (start sampled at edge 0) and follows it until done, bounded.
   task automatic run(input string tag, input int len, input int exp_done,
                      input int exp_stall, input int exp_pc, input bit inject);
      int   done_edge = -1;
      int   busy_bad  = 0;
      int   extra     = 0;
      exp_t e;
      bus.start    = 1'b1;
      bus.prog_len = 5'(len);
      for (int k = 0; k <= 60 && done_edge < 0; k++) begin
         @(posedge clk1); #1;
         if (k == 0) bus.start = 1'b0;
         if (bus.busy !== ((len > 0 && k < exp_done) ? 1'b1 : 1'b0)) busy_bad++;
         if (bus.issue_valid === 1'b1) begin
            if (sb.size() == 0) extra++;
            else begin
               e = sb.pop_front();
               check($sformatf("%s_edge", tag), 32'(k), 32'(e.edge_n));
               check($sformatf("%s_fields@%0d", tag, k), 32'(outs()), 32'(e.ins));
            end
         end
         if (bus.done === 1'b1) done_edge = k;
         if (inject && k == 2) begin
            bus.ld_en    = 1'b1;
            bus.ld_addr  = 4'd0;
            bus.ld_data  = mk(15, 10, 10, 10, 255);
            bus.start    = 1'b1;
            bus.prog_len = 5'd1;
         end
         if (inject && k == 3) begin
            bus.ld_en = 1'b0;
            bus.start = 1'b0;
         end
      end
      check($sformatf("%s_done_edge", tag), 32'(done_edge), 32'(exp_done));
      check($sformatf("%s_missing", tag), 32'(sb.size()), 32'd0);
      check($sformatf("%s_extra", tag), 32'(extra), 32'd0);
      check($sformatf("%s_busy", tag), 32'(busy_bad), 32'd0);
      check($sformatf("%s_stall", tag), 32'(bus.stall_cnt), 32'(exp_stall));
      if (exp_pc >= 0) check($sformatf("%s_pc", tag), 32'(bus.pc), 32'(exp_pc));
      sb.delete();
      @(posedge clk1); #1;
      check($sformatf("%s_done_pulse", tag), 32'(bus.done), 32'd0);
   endtask

   initial begin
      int hold_done;
      bus.ld_en    = 1'b0;
      bus.ld_addr  = '0;
      bus.ld_data  = '0;
      bus.start    = 1'b0;
      bus.prog_len = '0;

      repeat (3) @(posedge clk1);
      #1;
      check("rst_flags", 32'({bus.issue_valid, bus.busy, bus.done}), 32'd0);
      check("rst_pc_stall", 32'({bus.pc, bus.stall_cnt}), 32'd0);
      check("rst_fields", 32'(outs()), 32'd0);
      rst = 1'b0;
      @(posedge clk1); #1;

      // Independent program
      load(0, mk(2, 6, 1, 10, 125));
      load(1, mk(3, 9, 8, 12, 126));
      load(2, mk(4, 2, 4, 13, 125));
      expect_issue(1, mk(2, 6, 1, 10, 125));
      expect_issue(2, mk(3, 9, 8, 12, 126));
      expect_issue(3, mk(4, 2, 4, 13, 125));
      run("indep", 3, 7, 0, 3, 1'b0);

      // Back-to-back RAW: two bubbles
      load(0, mk(1, 1, 2, 10, 16));
      load(1, mk(5, 10, 3, 11, 32));
      expect_issue(1, mk(1, 1, 2, 10, 16));
      expect_issue(4, mk(5, 10, 3, 11, 32));
      run("raw", 2, 8, 2, 2, 1'b0);

      // Distance-2 dependency (entry1 also reads its own rd)
      load(0, mk(3, 1, 2, 5, 64));
      load(1, mk(6, 6, 4, 6, 65));
      load(2, mk(7, 7, 5, 8, 66));
      expect_issue(1, mk(3, 1, 2, 5, 64));
      expect_issue(2, mk(6, 6, 4, 6, 65));
      expect_issue(4, mk(7, 7, 5, 8, 66));
      run("dist2", 3, 8, 1, 3, 1'b0);

      // Empty program
      run("len0", 0, 0, 0, -1, 1'b0);

      // Load and start while running are ignored; rerun proves entry0 intact
      expect_issue(1, mk(3, 1, 2, 5, 64));
      expect_issue(2, mk(6, 6, 4, 6, 65));
      expect_issue(4, mk(7, 7, 5, 8, 66));
      run("ign", 3, 8, 1, 3, 1'b1);
      expect_issue(1, mk(3, 1, 2, 5, 64));
      expect_issue(2, mk(6, 6, 4, 6, 65));
      expect_issue(4, mk(7, 7, 5, 8, 66));
      run("rerun", 3, 8, 1, 3, 1'b0);

      // Reset mid-run
      bus.start    = 1'b1;
      bus.prog_len = 5'd3;
      @(posedge clk1); #1;
      bus.start = 1'b0;
      @(posedge clk1); #1;
      check("pre_rst_issue", 32'(bus.issue_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_flags", 32'({bus.issue_valid, bus.busy, bus.done}), 32'd0);
      check("midrst_pc_stall", 32'({bus.pc, bus.stall_cnt}), 32'd0);
      check("midrst_fields", 32'(outs()), 32'd0);
      hold_done = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk1); #1;
         if (bus.done !== 1'b0) hold_done++;
      end
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk1); #1;
         if (bus.done !== 1'b0) hold_done++;
      end
      check("midrst_no_done", 32'(hold_done), 32'd0);
      expect_issue(1, mk(3, 1, 2, 5, 64));
      expect_issue(2, mk(6, 6, 4, 6, 65));
      run("postrst", 2, 6, 0, 2, 1'b0);

      // Full buffer: 16 independent instructions, pc wraps
      for (int i = 0; i < DEPTH; i++) begin
         load(i, mk(i, i % 4, (i + 1) % 4, 8 + i % 8, i * 3 + 1));
         expect_issue(i + 1, mk(i, i % 4, (i + 1) % 4, 8 + i % 8, i * 3 + 1));
      end
      run("full", 16, 20, 0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_issuer.md
Name: pipe_issuer

Overview:
- Instruction issuer that sits in front of the 4-stage register/ALU/memory pipeline and drives its instruction inputs: rs1, rs2, rd, func and addr.
- Holds a small program buffer that is loaded through a write port. After a start pulse it issues one instruction per clock.
- The pipeline has no forwarding, so the issuer inserts bubbles on read-after-write hazards.
- When the program has drained through the pipeline it signals done.

Parameters:
- DEPTH, 16, number of program buffer entries (power of 2).
- HAZ_GAP, 2, number of issue slots after a producer during which its rd may not be read.
- DRAIN_CYC, 3, cycles spent waiting after the last issue before done is raised.

Ports:
- clk1  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- ld_en  input  1  program buffer write strobe.
- ld_addr  input  log2(DEPTH)  program buffer write index.
- ld_data  input  24  packed instruction {func[23:20], rs1[19:16], rs2[15:12], rd[11:8], addr[7:0]}.
- start  input  1  one-cycle pulse that begins execution.
- prog_len  input  log2(DEPTH)+1  number of instructions to issue, 0..DEPTH; sampled with start.
- busy  output  1  high from the edge that accepts start until the edge that raises done.
- done  output  1  one-cycle pulse at the end of the program.
- issue_valid  output  1  high when rs1/rs2/rd/func/addr hold a real instruction.
- rs1, rs2, rd  output  4 each  register specifiers.
- func  output  4  ALU function code.
- addr  output  8  memory address.
- pc  output  log2(DEPTH)  index of the next instruction to issue.
- stall_cnt  output  8  bubbles inserted in the current run; saturates at 255.

Behaviour:
- Reset (asynchronous, active-high):
  - state IDLE; all outputs 0; hazard tracker cleared.
  - Program buffer contents are not reset.
  - Reset mid-run aborts the run: no done pulse, outputs 0 immediately.
- Program buffer loading:
  - ld_en in IDLE or DONE writes ld_data to entry ld_addr at the edge.
  - ld_en while busy is ignored.
- States:
  - IDLE:
    - start with prog_len=0 -> DONE, with no issue.
    - start with prog_len>0 -> RUN; latch prog_len; pc=0, stall_cnt=0, busy=1.
  - RUN, each edge, evaluate entry[pc]:
    - Hazard: entry rs1 or rs2 equals the rd of any valid tracker slot.
    - No hazard -> register the entry fields onto the outputs, issue_valid=1, pc+1, push {1, rd} into the tracker.
    - Hazard -> issue_valid=0, specifier outputs hold their last values, stall_cnt+1 (saturating), push an invalid slot.
    - Tracker is a HAZ_GAP-deep shift register; it shifts on every RUN/DRAIN edge.
    - Back-to-back dependency with HAZ_GAP=2: exactly 2 bubbles between producer and consumer.
    - The edge that issues instruction prog_len-1 moves to DRAIN.
  - DRAIN:
    - issue_valid=0; tracker shifts invalid slots.
    - After DRAIN_CYC edges -> DONE.
  - DONE:
    - done=1 and busy=0 for one cycle, then IDLE.
    - pc and stall_cnt hold their final values until the next start.
- start while busy (RUN/DRAIN) is ignored.
- Latency: start sampled at edge 0; first issue_valid=1 after edge 1.
  - Conflict-free program of N instructions: last issue at edge N; done high after edge N+DRAIN_CYC+1.
- Self-dependency (rs1==rd inside one instruction) is not a hazard.
- Only earlier issued slots are compared.
- pc wraps naturally only when prog_len=DEPTH; the run ends at the same edge.

Test Plan:
- Reset check: rst asserted mid-RUN -> all outputs 0 immediately; no done; a following start with prog_len=2 runs cleanly.
- Independent program:
  - Load 3 entries: (func2,rs1=6,rs2=1,rd=10,addr125), (func3,9,8,12,126), (func4,2,4,13,125).
  - start, prog_len=3 -> issue_valid high on edges 1,2,3 with exactly those fields.
  - stall_cnt=0; done pulse after edge 7.
- RAW hazard:
  - Entry0 rd=10; entry1 rs1=10.
  - Response: entry0 at edge 1, bubbles at edges 2 and 3, entry1 at edge 4; stall_cnt=2; done after edge 8.
- Distance-2 dependency:
  - Entry2 reads the rd of entry0; entry1 is independent.
  - Response: entry2 at edge 4 with 1 bubble; stall_cnt=1.
- prog_len=0 -> done one cycle after start; issue_valid never high; busy stays 0.
- Ignored requests:
  - ld_en and start during RUN -> the buffer entry is unchanged (verified by a rerun) and the run is not restarted.
- Full program:
  - prog_len=16 with all-independent entries -> 16 consecutive issues; pc wraps to 0; done after edge 20.
